// File: rtl/com_adder_acc.sv
// rtl/com_adder_acc.sv - multi-cycle {mantissa, exponent} adder with streaming accumulate
module com_adder_acc #(
    parameter int MANTISSA = 11,
    parameter int EXPONENT = 5,
    localparam int DATA_WIDTH = MANTISSA + EXPONENT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_A,
    input  logic [DATA_WIDTH-1:0] in_B,
    input  logic                  in_acc,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_zero,
    output logic                  out_ovf
);
    localparam int LW = $clog2(MANTISSA) + 1;
    localparam int SW = (LW > EXPONENT + 1) ? LW : EXPONENT + 1;
    localparam logic [EXPONENT:0] MANT_LIM = (EXPONENT+1)'(MANTISSA);

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_OUT} state_t;

    state_t                state_q, state_d;
    logic [MANTISSA-1:0]   xm_q, xm_d, ym_q, ym_d;
    logic [EXPONENT-1:0]   xe_q, xe_d, ye_q, ye_d;
    logic [MANTISSA-1:0]   am_q, am_d, bm_q, bm_d;
    logic [EXPONENT-1:0]   emax_q, emax_d;
    logic [MANTISSA:0]     sum_q, sum_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  acc_active_q, acc_active_d;
    logic                  chain_ovf_q, chain_ovf_d;
    logic                  op_acc_q, op_acc_d, op_last_q, op_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_zero_q, out_zero_d, out_ovf_q, out_ovf_d;

    // Alignment of the latched operands
    logic                       x_ge_y;
    logic [EXPONENT:0]          d_diff;
    logic signed [MANTISSA-1:0] small_s;
    logic [MANTISSA-1:0]        sh_small, al_a, al_b;
    logic [EXPONENT-1:0]        al_emax;

    always_comb begin
        x_ge_y   = (xe_q >= ye_q);
        d_diff   = x_ge_y ? ({1'b0, xe_q} - {1'b0, ye_q}) : ({1'b0, ye_q} - {1'b0, xe_q});
        small_s  = x_ge_y ? ym_q : xm_q;
        sh_small = (d_diff >= MANT_LIM) ? '0 : (small_s >>> d_diff);
        if (x_ge_y) begin
            al_a    = xm_q;
            al_b    = sh_small;
            al_emax = xe_q;
        end else begin
            al_a    = sh_small;
            al_b    = ym_q;
            al_emax = ye_q;
        end
        // A zero mantissa must not drag the result exponent around
        if (xm_q == '0) begin
            al_a    = '0;
            al_b    = ym_q;
            al_emax = ye_q;
        end else if (ym_q == '0) begin
            al_a    = xm_q;
            al_b    = '0;
            al_emax = xe_q;
        end
    end

    // Normalisation of the registered sum
    logic [MANTISSA-1:0]   nm;
    logic [LW-1:0]         lz;
    logic                  found;
    logic [SW-1:0]         emax_ext, lz_ext, shamt;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  res_zero, res_ovf;

    always_comb begin
        res_data = '0;
        res_zero = 1'b0;
        res_ovf  = 1'b0;
        nm       = sum_q[MANTISSA-1:0];
        lz       = LW'(MANTISSA - 1);
        found    = 1'b0;
        for (int i = 0; i < MANTISSA - 1; i++) begin
            if (!found && (nm[MANTISSA-1-i] != nm[MANTISSA-2-i])) begin
                lz    = LW'(i);
                found = 1'b1;
            end
        end
        emax_ext = SW'(emax_q);
        lz_ext   = SW'(lz);
        // Shifting past exponent zero leaves a denormal instead
        shamt    = (lz_ext > emax_ext) ? emax_ext : lz_ext;
        if (sum_q == '0) begin
            res_zero = 1'b1;
        end else if (sum_q[MANTISSA] != sum_q[MANTISSA-1]) begin
            if (&emax_q) begin
                res_ovf  = 1'b1;
                res_data = {sum_q[MANTISSA], {(MANTISSA-1){~sum_q[MANTISSA]}}, {EXPONENT{1'b1}}};
            end else begin
                res_data = {sum_q[MANTISSA:1], emax_q + EXPONENT'(1)};
            end
        end else begin
            res_data = {nm << shamt, EXPONENT'(emax_ext - shamt)};
        end
    end

    always_comb begin
        state_d      = state_q;
        xm_d         = xm_q;
        xe_d         = xe_q;
        ym_d         = ym_q;
        ye_d         = ye_q;
        am_d         = am_q;
        bm_d         = bm_q;
        emax_d       = emax_q;
        sum_d        = sum_q;
        acc_d        = acc_q;
        acc_active_d = acc_active_q;
        chain_ovf_d  = chain_ovf_q;
        op_acc_d     = op_acc_q;
        op_last_d    = op_last_q;
        out_data_d   = out_data_q;
        out_zero_d   = out_zero_q;
        out_ovf_d    = out_ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_acc) begin
                        xm_d = acc_active_q ? acc_q[DATA_WIDTH-1:EXPONENT] : '0;
                        xe_d = acc_active_q ? acc_q[EXPONENT-1:0] : '0;
                        ym_d = in_A[DATA_WIDTH-1:EXPONENT];
                        ye_d = in_A[EXPONENT-1:0];
                    end else begin
                        xm_d = in_A[DATA_WIDTH-1:EXPONENT];
                        xe_d = in_A[EXPONENT-1:0];
                        ym_d = in_B[DATA_WIDTH-1:EXPONENT];
                        ye_d = in_B[EXPONENT-1:0];
                    end
                    op_acc_d  = in_acc;
                    op_last_d = in_last;
                    state_d   = S_ALIGN;
                end
            end
            S_ALIGN: begin
                am_d    = al_a;
                bm_d    = al_b;
                emax_d  = al_emax;
                state_d = S_ADD;
            end
            S_ADD: begin
                sum_d   = {am_q[MANTISSA-1], am_q} + {bm_q[MANTISSA-1], bm_q};
                state_d = S_NORM;
            end
            S_NORM: begin
                if (op_acc_q && !op_last_q) begin
                    acc_d        = res_data;
                    acc_active_d = 1'b1;
                    chain_ovf_d  = chain_ovf_q | res_ovf;
                    state_d      = S_IDLE;
                end else begin
                    out_data_d = res_data;
                    out_zero_d = res_zero;
                    out_ovf_d  = res_ovf | (op_acc_q & chain_ovf_q);
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    if (op_acc_q) begin
                        acc_d        = '0;
                        acc_active_d = 1'b0;
                        chain_ovf_d  = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            xm_q         <= '0;
            xe_q         <= '0;
            ym_q         <= '0;
            ye_q         <= '0;
            am_q         <= '0;
            bm_q         <= '0;
            emax_q       <= '0;
            sum_q        <= '0;
            acc_q        <= '0;
            acc_active_q <= 1'b0;
            chain_ovf_q  <= 1'b0;
            op_acc_q     <= 1'b0;
            op_last_q    <= 1'b0;
            out_data_q   <= '0;
            out_zero_q   <= 1'b0;
            out_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            xm_q         <= xm_d;
            xe_q         <= xe_d;
            ym_q         <= ym_d;
            ye_q         <= ye_d;
            am_q         <= am_d;
            bm_q         <= bm_d;
            emax_q       <= emax_d;
            sum_q        <= sum_d;
            acc_q        <= acc_d;
            acc_active_q <= acc_active_d;
            chain_ovf_q  <= chain_ovf_d;
            op_acc_q     <= op_acc_d;
            op_last_q    <= op_last_d;
            out_data_q   <= out_data_d;
            out_zero_q   <= out_zero_d;
            out_ovf_q    <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign out_data  = out_data_q;
    assign out_zero  = out_zero_q;
    assign out_ovf   = out_ovf_q;

endmodule
